mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 28 ++
 rtl/mem_access_ctrl_load_align.sv | 27 ++
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared opcode header: LOAD/STORE opcodes, funct3 encodings, and legality helpers
// for the MEM-stage access controller.
package mem_access_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // funct3[1:0] encodes the access size for every legal load and store.
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~lo[0];
            default: return lo == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// mem_load_align: selects the addressed byte/half/word from a 32-bit read word
// and sign- or zero-extends it according to funct3.
module mem_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer (IDLE/REQ/WAIT/DONE) with one
// outstanding request, word-aligned memory port, load timeout and registered writeback.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ex_valid,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_store_data,
    input  logic [4:0]        i_rd,
    output logic              o_stall,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic              o_mem_req_we,
    output logic [ADDR_W-1:0] o_mem_req_addr,
    output logic [31:0]       o_mem_req_wdata,
    output logic [3:0]        o_mem_req_wmask,
    input  logic              i_mem_resp_valid,
    input  logic [31:0]       i_mem_resp_rdata,
    output logic              o_wb_valid,
    output logic [4:0]        o_wb_rd,
    output logic [31:0]       o_wb_data,
    output logic              o_mem_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t            r_state;
    logic              r_req_valid;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wmask;
    logic [1:0]        r_addr_lo;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;
    logic [15:0]       r_count;
    logic              r_wb_valid;
    logic [31:0]       r_wb_data;
    logic              r_err;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_mem_op;
    logic        w_legal;
    logic        w_accept;
    logic        w_reject;
    logic [31:0] w_wdata;
    logic [3:0]  w_wmask;
    logic [31:0] w_load_data;

    assign w_is_load  = i_opcode == OPC_LOAD;
    assign w_is_store = i_opcode == OPC_STORE;
    assign w_mem_op   = i_ex_valid && (w_is_load || w_is_store);
    assign w_legal    = f3_legal(w_is_store, i_funct3) && addr_aligned(i_funct3, i_addr[1:0]);
    assign w_accept   = (r_state == S_IDLE) && w_mem_op && w_legal;
    assign w_reject   = (r_state == S_IDLE) && w_mem_op && !w_legal;

    // Gated by rst_n so every output reads 0 while reset is held, even with a live instruction.
    assign o_stall = rst_n && (w_accept || r_state == S_REQ || r_state == S_WAIT);

    always_comb begin
        w_wmask = 4'b0000;
        w_wdata = 32'd0;
        if (w_is_store) begin
            case (i_funct3[1:0])
                2'b00: begin
                    w_wmask = 4'b0001 << i_addr[1:0];
                    w_wdata = {4{i_store_data[7:0]}};
                end
                2'b01: begin
                    w_wmask = 4'b0011 << {i_addr[1], 1'b0};
                    w_wdata = {2{i_store_data[15:0]}};
                end
                default: begin
                    w_wmask = 4'b1111;
                    w_wdata = i_store_data;
                end
            endcase
        end
    end

    mem_load_align u_load_align (
        .i_rdata   (i_mem_resp_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    // NOTE: state uses non-blocking assignments so every branch reads the pre-edge values;
    // captured request fields are cleared too, so nothing stale leaks out after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_valid <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_addr_lo   <= '0;
            r_funct3    <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_data   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_valid <= 1'b1;
                        r_we        <= w_is_store;
                        r_addr      <= {i_addr[ADDR_W-1:2], 2'b00};
                        r_wdata     <= w_wdata;
                        r_wmask     <= w_wmask;
                        r_addr_lo   <= i_addr[1:0];
                        r_funct3    <= i_funct3;
                        r_rd        <= i_rd;
                        r_state     <= S_REQ;
                    end else if (w_reject) begin
                        r_err <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (i_mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_count     <= '0;
                        r_state     <= r_we ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_count <= r_count + 16'd1;
                    if (i_mem_resp_valid) begin
                        r_wb_data  <= w_load_data;
                        r_wb_valid <= r_rd != 5'd0;
                        r_state    <= S_DONE;
                    end else if (r_count == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_req_valid = r_req_valid;
    assign o_mem_req_we    = r_we;
    assign o_mem_req_addr  = r_addr;
    assign o_mem_req_wdata = r_wdata;
    assign o_mem_req_wmask = r_wmask;
    assign o_wb_valid      = r_wb_valid;
    assign o_wb_rd         = r_rd;
    assign o_wb_data       = r_wb_data;
    assign o_mem_err       = r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// load/store traffic checked against a transaction-level reference model.
module tb_mem_access_ctrl;

    localparam int         ADDR_W = 32;
    localparam int         TMO    = 4;
    localparam logic [6:0] OPC_LD = 7'h03;
    localparam logic [6:0] OPC_ST = 7'h23;
    localparam logic [6:0] OPC_OP = 7'h33;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_ex_valid;
    logic [6:0]        i_opcode;
    logic [2:0]        i_funct3;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_store_data;
    logic [4:0]        i_rd;
    logic              o_stall;
    logic              o_mem_req_valid;
    logic              i_mem_req_ready;
    logic              o_mem_req_we;
    logic [ADDR_W-1:0] o_mem_req_addr;
    logic [31:0]       o_mem_req_wdata;
    logic [3:0]        o_mem_req_wmask;
    logic              i_mem_resp_valid;
    logic [31:0]       i_mem_resp_rdata;
    logic              o_wb_valid;
    logic [4:0]        o_wb_rd;
    logic [31:0]       o_wb_data;
    logic              o_mem_err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_ex_valid       (i_ex_valid),
        .i_opcode         (i_opcode),
        .i_funct3         (i_funct3),
        .i_addr           (i_addr),
        .i_store_data     (i_store_data),
        .i_rd             (i_rd),
        .o_stall          (o_stall),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_req_we     (o_mem_req_we),
        .o_mem_req_addr   (o_mem_req_addr),
        .o_mem_req_wdata  (o_mem_req_wdata),
        .o_mem_req_wmask  (o_mem_req_wmask),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_resp_rdata (i_mem_resp_rdata),
        .o_wb_valid       (o_wb_valid),
        .o_wb_rd          (o_wb_rd),
        .o_wb_data        (o_wb_data),
        .o_mem_err        (o_mem_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random junk on the instruction and response inputs; the DUT must ignore it outside IDLE/WAIT.
    task automatic scramble();
        int k;
        k = $urandom_range(0, 2);
        i_ex_valid       = 1'($urandom_range(0, 1));
        i_opcode         = (k == 0) ? OPC_LD : (k == 1) ? OPC_ST : OPC_OP;
        i_funct3         = 3'($urandom_range(0, 7));
        i_addr           = $urandom;
        i_store_data     = $urandom;
        i_rd             = 5'($urandom_range(0, 31));
        i_mem_resp_valid = 1'($urandom_range(0, 1));
        i_mem_resp_rdata = $urandom;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stall"}, 32'(o_stall), 0);
        check({tag, "_reqv"},  32'(o_mem_req_valid), 0);
        check({tag, "_we"},    32'(o_mem_req_we), 0);
        check({tag, "_addr"},  o_mem_req_addr, 0);
        check({tag, "_wdata"}, o_mem_req_wdata, 0);
        check({tag, "_wmask"}, 32'(o_mem_req_wmask), 0);
        check({tag, "_wbv"},   32'(o_wb_valid), 0);
        check({tag, "_wbrd"},  32'(o_wb_rd), 0);
        check({tag, "_wbd"},   o_wb_data, 0);
        check({tag, "_err"},   32'(o_mem_err), 0);
    endtask

    // ---- reference model: plain arithmetic on sizes and byte offsets ----
    function automatic bit m_legal(input bit st, input int f3, input logic [31:0] a);
        int sz;
        sz = f3 % 4;
        if (st && f3 > 2) return 0;
        if (!st && (f3 == 3 || f3 > 5)) return 0;
        return (int'(a[1:0]) % (1 << sz)) == 0;
    endfunction

    function automatic logic [31:0] m_load(input int f3, input int lo, input logic [31:0] rd_word);
        longint v;
        case (f3)
            0, 4: begin
                v = (rd_word >> (8 * lo)) & 32'hFF;
                if (f3 == 0 && v >= 128) v -= 256;
            end
            1, 5: begin
                v = (rd_word >> (16 * (lo / 2))) & 32'hFFFF;
                if (f3 == 1 && v >= 32768) v -= 65536;
            end
            default: v = rd_word;
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_mask(input int f3, input int lo);
        int n;
        n = 1 << (f3 % 4);
        return 4'(((1 << n) - 1) << lo);
    endfunction

    function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] sd);
        case (f3 % 4)
            0:       return (sd & 32'hFF) * 32'h0101_0101;
            1:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    // One instruction from IDLE to completion. resp_dly < 0 means no response (timeout).
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd, input int rdy_dly,
                         input int resp_dly, input logic [31:0] rdata);
        bit          ok;
        int          n_wait;
        logic [31:0] exp_addr;
        ok       = m_legal(st, int'(f3), a);
        exp_addr = {a[31:2], 2'b00};

        i_ex_valid = 1'b1; i_opcode = st ? OPC_ST : OPC_LD; i_funct3 = f3; i_addr = a;
        i_store_data = sd; i_rd = rd; i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b0;
        #1;
        check("idle_err_quiet", 32'(o_mem_err), 0);
        check("accept_stall", 32'(o_stall), 32'(ok));
        check("idle_no_req", 32'(o_mem_req_valid), 0);
        tick();

        if (!ok) begin
            i_ex_valid = 1'b0;
            #1;
            check("err_pulse", 32'(o_mem_err), 1);
            check("err_no_req", 32'(o_mem_req_valid), 0);
            check("err_stall", 32'(o_stall), 0);
            tick();
            check("err_one_cycle", 32'(o_mem_err), 0);
            check("err_still_no_req", 32'(o_mem_req_valid), 0);
            return;
        end

        for (int c = 0; c <= rdy_dly; c++) begin
            scramble();
            i_mem_req_ready = (c == rdy_dly);
            #1;
            check("req_valid", 32'(o_mem_req_valid), 1);
            check("req_addr", o_mem_req_addr, exp_addr);
            check("req_we", 32'(o_mem_req_we), 32'(st));
            check("req_wmask", 32'(o_mem_req_wmask), st ? 32'(m_mask(int'(f3), int'(a[1:0]))) : 0);
            check("req_wdata", o_mem_req_wdata, st ? m_wdata(int'(f3), sd) : 0);
            check("req_stall", 32'(o_stall), 1);
            check("req_no_wb", 32'(o_wb_valid), 0);
            tick();
        end
        i_mem_req_ready = 1'b0;

        if (!st) begin
            n_wait = (resp_dly < 0) ? TMO : resp_dly;
            for (int c = 0; c < n_wait; c++) begin
                scramble();
                i_mem_resp_valid = 1'b0;
                #1;
                check("wait_stall", 32'(o_stall), 1);
                check("wait_no_req", 32'(o_mem_req_valid), 0);
                check("wait_no_wb", 32'(o_wb_valid), 0);
                check("wait_no_err", 32'(o_mem_err), 0);
                tick();
            end
            if (resp_dly >= 0) begin
                scramble();
                i_mem_resp_valid = 1'b1;
                i_mem_resp_rdata = rdata;
                #1;
                check("resp_stall", 32'(o_stall), 1);
                tick();
            end
        end

        // DONE: inputs are junk and must be ignored.
        scramble();
        #1;
        check("done_stall", 32'(o_stall), 0);
        check("done_no_req", 32'(o_mem_req_valid), 0);
        check("done_err", 32'(o_mem_err), 32'(!st && resp_dly < 0));
        check("done_wbv", 32'(o_wb_valid), 32'(!st && resp_dly >= 0 && rd != 0));
        if (!st && resp_dly >= 0 && rd != 0) begin
            check("done_wbrd", 32'(o_wb_rd), 32'(rd));
            check("done_wbdata", o_wb_data, m_load(int'(f3), int'(a[1:0]), rdata));
        end
        tick();
    endtask

    task automatic do_nop(input bit valid, input logic [6:0] opc);
        i_ex_valid = valid; i_opcode = opc;
        i_funct3 = 3'($urandom_range(0, 7)); i_addr = $urandom; i_store_data = $urandom;
        i_rd = 5'($urandom_range(0, 31)); i_mem_req_ready = 1'b0;
        i_mem_resp_valid = 1'($urandom_range(0, 1)); i_mem_resp_rdata = $urandom;
        #1;
        check("nop_stall", 32'(o_stall), 0);
        check("nop_no_req", 32'(o_mem_req_valid), 0);
        check("nop_err", 32'(o_mem_err), 0);
        tick();
    endtask

    initial begin
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          kind;
        int          resp;

        rst_n = 1'b0;
        i_ex_valid = 1'b1; i_opcode = OPC_LD; i_funct3 = 3'b010; i_addr = 32'h100;
        i_store_data = 32'hDEAD_BEEF; i_rd = 5'd3; i_mem_req_ready = 1'b1;
        i_mem_resp_valid = 1'b1; i_mem_resp_rdata = 32'hFFFF_FFFF;
        #1;
        check_zero("rst");
        repeat (2) tick();
        check_zero("rst_hold");
        i_ex_valid = 1'b0; i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b0;
        #1 rst_n = 1'b1;
        tick();

        // LB sign-extend from top byte, immediate ready/response (3-cycle latency)
        do_op(1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd7, 0, 0, 32'h80FF_FF7F);
        // SH upper half
        do_op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd3, 0, 0, 32'd0);
        // misaligned LW
        do_op(1'b0, 3'b010, 32'h0000_3001, 32'd0, 5'd4, 0, 0, 32'd0);
        // ready held low for 5 cycles
        do_op(1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd9, 5, 1, 32'hCAFE_F00D);
        do_op(1'b1, 3'b000, 32'h0000_4001, 32'h0000_005A, 5'd1, 5, 0, 32'd0);
        // timeout
        do_op(1'b0, 3'b101, 32'h0000_5002, 32'd0, 5'd12, 0, -1, 32'd0);
        // rd = 0 suppresses writeback
        do_op(1'b0, 3'b000, 32'h0000_6001, 32'd0, 5'd0, 0, 0, 32'h1122_3344);
        // illegal store funct3
        do_op(1'b1, 3'b011, 32'h0000_7000, 32'h1, 5'd2, 0, 0, 32'd0);

        // reset while in WAIT, then a late response after release
        i_ex_valid = 1'b1; i_opcode = OPC_LD; i_funct3 = 3'b010; i_addr = 32'h0000_8000;
        i_rd = 5'd6; i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b0;
        tick();
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        #1;
        check("wait_before_rst", 32'(o_stall), 1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_wait");
        tick();
        check_zero("rst_wait_hold");
        #2 rst_n = 1'b1;
        i_ex_valid = 1'b0; i_mem_resp_valid = 1'b1; i_mem_resp_rdata = 32'h5555_AAAA;
        tick();
        i_mem_resp_valid = 1'b0;
        #1;
        check("late_resp_wbv", 32'(o_wb_valid), 0);
        check("late_resp_stall", 32'(o_stall), 0);
        check("late_resp_req", 32'(o_mem_req_valid), 0);
        tick();
        check("late_resp_wbv2", 32'(o_wb_valid), 0);

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                do_nop(kind == 1, (kind == 0) ? OPC_LD : OPC_OP);
            end else begin
                st = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0)
                    f3 = st ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) + 3) % 6);
                a = $urandom;
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
                resp = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TMO - 1);
                do_op(st, f3, a, $urandom, 5'($urandom_range(0, 31)),
                      $urandom_range(0, 3), resp, $urandom);
            end
        end

        do_nop(1'b0, OPC_OP);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
